ysyx_24100006_csr_file: RTL
===========================

# ysyx_24100006_csr_file

Machine-mode CSR file for the ID/EXE boundary of the ysyx_24100006 core, successor to the fixed-function CSR block. It adds:
- parametrised data width;
- atomic CSR write/set/clear operations;
- hardware trap entry and `mret` exit sequencing with `mstatus.MIE`/`MPIE` save/restore;
- writable `mcause`;
- 64-bit free-running `mcycle` and retire-driven `minstret` counters.

It feeds `mtvec`/`mepc` to the PC-select logic and reports illegal CSR accesses to the decoder.

## Interface
Parameters:
- `DATA_WIDTH`, 32, XLEN; only 32 or 64 are legal.
- `ADDR_WIDTH`, 12, CSR address width.
- `VENDOR_ID`, 32'h79737978, value returned for `mvendorid`.
- `ARCH_ID`, 32'd24100006, value returned for `marchid`.

Ports:
- `clk` in 1: single clock; all state updates on posedge.
- `reset` in 1: synchronous, active-high.
- `wen` in 1: CSR instruction write request.
- `wop` in 2: 00 write, 01 set (`old|wdata`), 10 clear (`old&~wdata`), 11 treated as no write.
- `waddr` in `ADDR_WIDTH`: write target.
- `wdata` in `DATA_WIDTH`: write operand.
- `raddr` in `ADDR_WIDTH`: read address (instr[31:20]).
- `rdata` out `DATA_WIDTH`: combinational read data.
- `illegal` out 1: combinational; set when `raddr` is unimplemented, or `wen` targets a read-only/unimplemented CSR.
- `trap_valid` in 1: take a trap this cycle.
- `trap_pc` in `DATA_WIDTH`: faulting PC.
- `trap_cause` in `DATA_WIDTH`: cause code.
- `mret_valid` in 1: execute `mret` this cycle.
- `retire` in 1: one instruction retired this cycle.
- `mtvec` out `DATA_WIDTH`: registered trap vector.
- `mepc` out `DATA_WIDTH`: registered return PC.
- `mie` out 1: registered `mstatus.MIE`.

## Operation
Implemented CSRs:

| CSR | Address | Behaviour |
|---|---|---|
| `mstatus` | 0x300 | Only MIE (bit 3) and MPIE (bit 7) are writable. MPP (bits 12:11) is hard-wired to 2'b11. All other bits read 0. |
| `mtvec` | 0x305 | Bits [1:0] are forced to 0 (direct mode only). |
| `mepc` | 0x341 | Bits [1:0] are forced to 0. |
| `mcause` | 0x342 | Fully writable. |
| `mcycle` | 0xB00 | Low half of the 64-bit cycle counter. |
| `mcycleh` | 0xB80 | High half; only when `DATA_WIDTH`=32. |
| `minstret` | 0xB02 | Low half of the 64-bit retire counter. |
| `minstreth` | 0xB82 | High half; only when `DATA_WIDTH`=32. |
| `mvendorid` | 0xF11 | Read-only constant. |
| `marchid` | 0xF12 | Read-only constant. |

General rules:
- `mvendorid`/`marchid` are zero-extended to `DATA_WIDTH`.
- With `DATA_WIDTH`=64, the counter CSRs at 0xB00/0xB02 return the full 64 bits, and 0xB80/0xB82 are unimplemented.
- Unimplemented reads return 0 with `illegal`=1.
- Writes to read-only CSRs (address[11:10]=2'b11) or unimplemented CSRs are dropped with `illegal`=1.

Event priority within one cycle is trap > mret > CSR write:
- **Trap:** `mepc`←`trap_pc`&~3, `mcause`←`trap_cause`, MPIE←MIE, MIE←0. Any concurrent `wen` or `mret_valid` is ignored.
- **mret:** MIE←MPIE, MPIE←1. A concurrent `wen` is ignored.
- **Write:** new value = f(`wop`, current value, `wdata`), then masked as described above.

Counters:
- `mcycle` increments by 1 every cycle not in reset.
- `minstret` increments by 1 when `retire`=1.
- Both wrap from 2^64−1 to 0.
- A CSR write to any half of a counter overrides that cycle's increment for the whole counter. The written half takes the new value and the other half holds.
- Counter writes still happen during a cycle in which a trap or mret is also taken; the priority rule applies only to non-counter CSRs.

## Timing
- `rdata`/`illegal` are combinational from current state. A read of a CSR being written in the same cycle returns the old value; the new value is visible the next cycle.
- All writes, trap/mret effects and counter increments take effect at the posedge. `mtvec`/`mepc`/`mie` reflect them the following cycle (1-cycle latency).
- Reset values: `mstatus`=0x1800 (MIE=0, MPIE=0), `mtvec`=0, `mepc`=0, `mcause`=0, `mcycle`=0, `minstret`=0.
- During reset, `rdata` follows the reset state and the counters do not increment.
- Reset asserted in the same cycle as a trap or write: reset wins; the trap or write is lost.
- `mcycle` first reads 1 in the cycle after reset deasserts.
- `trap_valid`/`mret_valid` are single-cycle pulses, with no handshake or backpressure. A pulse held for N cycles acts N times.

## Structure
- Package `ysyx_24100006_csr_pkg` holds:
  - CSR address localparams;
  - `wop` encodings;
  - `mstatus` bit indices (MIE=3, MPIE=7, MPP=12:11);
  - the `mtvec`/`mepc` alignment mask.
- Sub-module `ysyx_24100006_csr_counter64` is instantiated twice (`mcycle`, `minstret`). Its ports are: `inc`, `wr_lo`, `wr_hi`, `wdata`, `value[63:0]`. It owns increment, wrap-around and write-override.
- Top level contains the read mux, the write ALU (write/set/clear), the priority logic and the `mstatus`/`mtvec`/`mepc`/`mcause` registers.

## Test plan
- **Reset:** assert `reset` 2 cycles. Read 0x300 → 0x1800, 0x305 → 0, 0x342 → 0; `mie`=0. Read 0xF11 → 0x79737978, 0xF12 → 24100006.
- **Write/set/clear:**
  - write 0x305 with 0x80000003 → reads 0x80000000 next cycle;
  - set 0x300 with 0x8 → `mie`=1 and `rdata`=0x1808;
  - clear 0x300 with 0x8 → 0x1800.
- **Trap then mret:**
  - with MIE=1, pulse trap (`trap_pc`=0x80000104, `trap_cause`=0xB) → `mepc`=0x80000104, `mcause`=0xB, 0x300 reads 0x1880, `mie`=0;
  - pulse mret → 0x300 reads 0x1888, `mie`=1.
- **Priority:**
  - trap + `wen` to 0x341 (0x1234) in the same cycle → `mepc`=`trap_pc`;
  - mret + set 0x300 (0x8) with MPIE=0 → MIE=0, MPIE=1.
- **Counter wrap:**
  - write 0xB80 ← 0xFFFFFFFF and 0xB00 ← 0xFFFFFFFE (`DATA_WIDTH`=32) → two cycles later 0xB00=0, 0xB80=0;
  - `retire` held 5 cycles → `minstret` +5.
- **Illegal:**
  - read 0x7C0 → `rdata`=0, `illegal`=1;
  - write 0xF11 → `illegal`=1 and the value is unchanged.

Source files
------------

// File: rtl/ysyx_24100006_csr_pkg.sv
// Shared constants for the ysyx_24100006 machine-mode CSR file:
// CSR addresses, write-operation encodings, mstatus bit positions
// and the alignment mask applied to mtvec/mepc.
package ysyx_24100006_csr_pkg;

  // CSR addresses (12-bit CSR space)
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;

  // Write-operation encodings carried on the wop port
  typedef enum logic [1:0] {
    WOP_WRITE = 2'b00,
    WOP_SET   = 2'b01,
    WOP_CLEAR = 2'b10,
    WOP_NONE  = 2'b11
  } wop_e;

  // mstatus field positions
  localparam int unsigned MSTATUS_MIE    = 3;
  localparam int unsigned MSTATUS_MPIE   = 7;
  localparam int unsigned MSTATUS_MPP_LO = 11;
  localparam int unsigned MSTATUS_MPP_HI = 12;
  localparam logic [1:0]  MSTATUS_MPP_M  = 2'b11;

  // mtvec/mepc keep 4-byte alignment; sliced to XLEN where used
  localparam logic [63:0] ALIGN_MASK = ~64'h3;

endpackage

// File: rtl/ysyx_24100006_csr_counter64.sv
// 64-bit counter behind mcycle/minstret. Owns increment, wrap-around and
// CSR write override. With DATA_WIDTH=64 a low write replaces all 64 bits;
// with DATA_WIDTH=32 each half is written independently.
module ysyx_24100006_csr_counter64 #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  inc,
  input  logic                  wr_lo,
  input  logic                  wr_hi,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [63:0]           value
);

  logic [63:0] value_d;
  logic [63:0] value_q;

  // Next value: any write to either half suppresses this cycle's increment.
  always_comb begin
    // NOTE: default first so every path assigns value_d and no latch is inferred.
    value_d = value_q;
    if (wr_lo || wr_hi) begin
      if (wr_lo) value_d[DATA_WIDTH-1:0] = wdata;
      if (wr_hi) value_d[63:32] = wdata[31:0];
    end else if (inc) begin
      value_d = value_q + 64'd1;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all flop updates so every register samples pre-edge values.
    if (reset) value_q <= '0;
    else       value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/ysyx_24100006_csr_file.sv
// Machine-mode CSR file: read mux, write/set/clear ALU, trap/mret sequencing
// with MIE/MPIE save-restore, and the mstatus/mtvec/mepc/mcause registers.
// The two 64-bit counters live in ysyx_24100006_csr_counter64.
// DATA_WIDTH must be 32 or 64.
module ysyx_24100006_csr_file
  import ysyx_24100006_csr_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 12,
  parameter logic [31:0] VENDOR_ID  = 32'h79737978,
  parameter logic [31:0] ARCH_ID    = 32'd24100006
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wen,
  input  logic [1:0]            wop,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  illegal,
  input  logic                  trap_valid,
  input  logic [DATA_WIDTH-1:0] trap_pc,
  input  logic [DATA_WIDTH-1:0] trap_cause,
  input  logic                  mret_valid,
  input  logic                  retire,
  output logic [DATA_WIDTH-1:0] mtvec,
  output logic [DATA_WIDTH-1:0] mepc,
  output logic                  mie
);

  localparam logic [DATA_WIDTH-1:0] AlignMask = ALIGN_MASK[DATA_WIDTH-1:0];

  logic                  mie_d,    mie_q;
  logic                  mpie_d,   mpie_q;
  logic [DATA_WIDTH-1:0] mtvec_d,  mtvec_q;
  logic [DATA_WIDTH-1:0] mepc_d,   mepc_q;
  logic [DATA_WIDTH-1:0] mcause_d, mcause_q;

  logic [63:0]           mcycle_val;
  logic [63:0]           minstret_val;
  logic [DATA_WIDTH-1:0] mstatus_rd;

  wop_e                  wop_op;
  logic                  wr_legal;
  logic                  wr_fire;
  logic [DATA_WIDTH-1:0] wr_old;
  logic [DATA_WIDTH-1:0] wr_val;

  // True when addr names a CSR that exists at this XLEN.
  function automatic logic csr_exists(input logic [ADDR_WIDTH-1:0] addr);
    case (addr)
      CSR_MSTATUS, CSR_MTVEC, CSR_MEPC, CSR_MCAUSE,
      CSR_MCYCLE, CSR_MINSTRET, CSR_MVENDORID, CSR_MARCHID: return 1'b1;
      CSR_MCYCLEH, CSR_MINSTRETH:                           return DATA_WIDTH == 32;
      default:                                              return 1'b0;
    endcase
  endfunction

  // Current value of the CSR at addr; zero for anything unimplemented.
  function automatic logic [DATA_WIDTH-1:0] csr_read(input logic [ADDR_WIDTH-1:0] addr);
    if (!csr_exists(addr)) return '0;
    case (addr)
      CSR_MSTATUS:   return mstatus_rd;
      CSR_MTVEC:     return mtvec_q;
      CSR_MEPC:      return mepc_q;
      CSR_MCAUSE:    return mcause_q;
      CSR_MCYCLE:    return mcycle_val[DATA_WIDTH-1:0];
      CSR_MINSTRET:  return minstret_val[DATA_WIDTH-1:0];
      CSR_MCYCLEH:   return DATA_WIDTH'(mcycle_val[63:32]);
      CSR_MINSTRETH: return DATA_WIDTH'(minstret_val[63:32]);
      CSR_MVENDORID: return DATA_WIDTH'(VENDOR_ID);
      CSR_MARCHID:   return DATA_WIDTH'(ARCH_ID);
      default:       return '0;
    endcase
  endfunction

  // Write/set/clear against the current CSR value.
  function automatic logic [DATA_WIDTH-1:0] csr_alu(input wop_e op,
                                                    input logic [DATA_WIDTH-1:0] old,
                                                    input logic [DATA_WIDTH-1:0] operand);
    case (op)
      WOP_WRITE: return operand;
      WOP_SET:   return old | operand;
      WOP_CLEAR: return old & ~operand;
      default:   return old;
    endcase
  endfunction

  // Assemble the architectural mstatus view: MIE, MPIE, MPP fixed to M-mode.
  always_comb begin
    mstatus_rd = '0;
    mstatus_rd[MSTATUS_MIE]                   = mie_q;
    mstatus_rd[MSTATUS_MPIE]                  = mpie_q;
    mstatus_rd[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = MSTATUS_MPP_M;
  end

  // Read port, write legality and write-operand computation.
  always_comb begin
    wop_op   = wop_e'(wop);
    rdata    = csr_read(raddr);
    wr_legal = csr_exists(waddr) && (waddr[ADDR_WIDTH-1 -: 2] != 2'b11);
    illegal  = !csr_exists(raddr) || (wen && !wr_legal);
    wr_fire  = wen && wr_legal && (wop_op != WOP_NONE);
    wr_old   = csr_read(waddr);
    wr_val   = csr_alu(wop_op, wr_old, wdata);
  end

  // Next-state for non-counter CSRs with trap > mret > write priority.
  always_comb begin
    mie_d    = mie_q;
    mpie_d   = mpie_q;
    mtvec_d  = mtvec_q;
    mepc_d   = mepc_q;
    mcause_d = mcause_q;
    if (trap_valid) begin
      mepc_d   = trap_pc & AlignMask;
      mcause_d = trap_cause;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
    end else if (mret_valid) begin
      mie_d    = mpie_q;
      mpie_d   = 1'b1;
    end else if (wr_fire) begin
      case (waddr)
        CSR_MSTATUS: begin
          mie_d  = wr_val[MSTATUS_MIE];
          mpie_d = wr_val[MSTATUS_MPIE];
        end
        CSR_MTVEC:  mtvec_d  = wr_val & AlignMask;
        CSR_MEPC:   mepc_d   = wr_val & AlignMask;
        CSR_MCAUSE: mcause_d = wr_val;
        default: ;
      endcase
    end
  end

  // CSR registers with synchronous reset; reset beats any concurrent event.
  always_ff @(posedge clk) begin
    if (reset) begin
      mie_q    <= 1'b0;
      mpie_q   <= 1'b0;
      mtvec_q  <= '0;
      mepc_q   <= '0;
      mcause_q <= '0;
    end else begin
      mie_q    <= mie_d;
      mpie_q   <= mpie_d;
      mtvec_q  <= mtvec_d;
      mepc_q   <= mepc_d;
      mcause_q <= mcause_d;
    end
  end

  // Counter writes are not subject to trap/mret priority.
  ysyx_24100006_csr_counter64 #(.DATA_WIDTH(DATA_WIDTH)) u_mcycle (
    .clk   (clk),
    .reset (reset),
    .inc   (1'b1),
    .wr_lo (wr_fire && (waddr == CSR_MCYCLE)),
    .wr_hi (wr_fire && (waddr == CSR_MCYCLEH)),
    .wdata (wr_val),
    .value (mcycle_val)
  );

  ysyx_24100006_csr_counter64 #(.DATA_WIDTH(DATA_WIDTH)) u_minstret (
    .clk   (clk),
    .reset (reset),
    .inc   (retire),
    .wr_lo (wr_fire && (waddr == CSR_MINSTRET)),
    .wr_hi (wr_fire && (waddr == CSR_MINSTRETH)),
    .wdata (wr_val),
    .value (minstret_val)
  );

  assign mtvec = mtvec_q;
  assign mepc  = mepc_q;
  assign mie   = mie_q;

endmodule
